// File: rtl/dem_pkg.sv
// Shared types and defaults for the dynamic element matching stages.
package dem_pkg;
  localparam int N_ELEM_DEF = 31;
  localparam int PTR_W_DEF  = 5;

  typedef logic [N_ELEM_DEF-1:0] therm_t;
  typedef logic [PTR_W_DEF-1:0]  ptr_t;
endpackage

// File: rtl/dwa_rotator_therm_count.sv
// Popcount of a thermometer vector plus a check that it is LSB-packed.
import dem_pkg::*;

module therm_count #(
  parameter int N_ELEM = N_ELEM_DEF,
  parameter int PTR_W  = PTR_W_DEF
) (
  input  logic [N_ELEM-1:0] vec,
  output logic [PTR_W:0]    k,
  output logic              therm_ok
);

  logic [PTR_W:0]    cnt;
  logic [N_ELEM-1:0] ref_mask;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      cnt = cnt + (PTR_W+1)'(vec[i]);
    end
    ref_mask = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      ref_mask[i] = ((PTR_W+1)'(i) < cnt);
    end
  end

  assign k        = cnt;
  assign therm_ok = (vec == ref_mask);

endmodule

// File: rtl/dwa_rotator.sv
// DWA element rotator: rotates an LSB-packed k-of-N mask around a
// circular pointer so unit elements are used in cycling order.
import dem_pkg::*;

module dwa_rotator #(
  parameter int N_ELEM = N_ELEM_DEF,
  parameter int PTR_W  = PTR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [N_ELEM-1:0] in_therm,
  input  logic              dwa_en,
  output logic              out_valid,
  output logic [N_ELEM-1:0] out_sel,
  output logic [PTR_W-1:0]  ptr,
  output logic              therm_err
);

  localparam logic [PTR_W:0] N_W = (PTR_W+1)'(N_ELEM);

  logic [PTR_W:0]      k;
  logic                therm_ok;
  logic [N_ELEM-1:0]   mask;
  logic [2*N_ELEM-1:0] dbl;
  logic [N_ELEM-1:0]   rot;
  logic [PTR_W:0]      sum;
  logic [PTR_W:0]      wrap;

  logic [N_ELEM-1:0] sel_q, sel_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              vld_q, vld_d;
  logic              err_q, err_d;

  therm_count #(
    .N_ELEM (N_ELEM),
    .PTR_W  (PTR_W)
  ) u_cnt (
    .vec      (in_therm),
    .k        (k),
    .therm_ok (therm_ok)
  );

  // Mask rebuilt from k so malformed codes still consume k elements.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      mask[i] = ((PTR_W+1)'(i) < k);
    end
    dbl  = {mask, mask} << ptr_q;
    rot  = dbl[2*N_ELEM-1:N_ELEM];
    sum  = {1'b0, ptr_q} + k;
    wrap = (sum >= N_W) ? (sum - N_W) : sum;
  end

  always_comb begin
    sel_d = sel_q;
    ptr_d = ptr_q;
    err_d = err_q;
    vld_d = in_valid;
    if (in_valid) begin
      err_d = !therm_ok;
      if (dwa_en) begin
        sel_d = rot;
        ptr_d = wrap[PTR_W-1:0];
      end else begin
        sel_d = in_therm;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= '0;
      ptr_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end

  assign out_valid = vld_q;
  assign out_sel   = sel_q;
  assign ptr       = ptr_q;
  assign therm_err = err_q;

endmodule

// File: tb/tb_dwa_rotator.sv
// Directed vector bench for dwa_rotator.
module tb_dwa_rotator;
  import dem_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   in_valid = 1'b0;
  therm_t in_therm = '0;
  logic   dwa_en = 1'b1;
  logic   out_valid;
  therm_t out_sel;
  ptr_t   ptr;
  logic   therm_err;

  int n_pass = 0;
  int n_total = 0;

  dwa_rotator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_therm  (in_therm),
    .dwa_en    (dwa_en),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .ptr       (ptr),
    .therm_err (therm_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic   v;
    logic   en;
    therm_t th;
    therm_t sel;
    ptr_t   p;
    logic   err;
    logic   ov;
  } vec_t;

  vec_t tv[15];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input therm_t sel,
                         input ptr_t p, input logic err, input logic ov);
    chk({tag, ".sel"}, 64'(out_sel), 64'(sel));
    chk({tag, ".ptr"}, 64'(ptr), 64'(p));
    chk({tag, ".err"}, 64'(therm_err), 64'(err));
    chk({tag, ".vld"}, 64'(out_valid), 64'(ov));
  endtask

  // Drive at a falling edge; the next falling edge is the sample point.
  task automatic step(input logic v, input logic en, input therm_t th);
    in_valid = v;
    dwa_en   = en;
    in_therm = th;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tv[0]  = '{1, 1, 31'h0000_0007, 31'h0000_0007, 5'd3,  0, 1};
    tv[1]  = '{1, 1, 31'h0000_001F, 31'h0000_00F8, 5'd8,  0, 1};
    tv[2]  = '{1, 1, 31'h0000_03FF, 31'h0003_FF00, 5'd18, 0, 1};
    tv[3]  = '{0, 1, 31'h0000_0001, 31'h0003_FF00, 5'd18, 0, 0};
    tv[4]  = '{1, 1, 31'h0000_03FF, 31'h0FFC_0000, 5'd28, 0, 1};
    tv[5]  = '{1, 1, 31'h0000_001F, 31'h7000_0003, 5'd2,  0, 1};
    tv[6]  = '{1, 1, 31'h0000_03FF, 31'h0000_0FFC, 5'd12, 0, 1};
    tv[7]  = '{1, 1, 31'h0000_0000, 31'h0000_0000, 5'd12, 0, 1};
    tv[8]  = '{1, 1, 31'h7FFF_FFFF, 31'h7FFF_FFFF, 5'd12, 0, 1};
    tv[9]  = '{1, 1, 31'h0000_0005, 31'h0000_3000, 5'd14, 1, 1};
    tv[10] = '{1, 0, 31'h0000_001F, 31'h0000_001F, 5'd14, 0, 1};
    tv[11] = '{1, 0, 31'h0000_0005, 31'h0000_0005, 5'd14, 1, 1};
    tv[12] = '{1, 1, 31'h0000_0001, 31'h0000_4000, 5'd15, 0, 1};
    tv[13] = '{1, 1, 31'h0000_FFFF, 31'h7FFF_8000, 5'd0,  0, 1};
    tv[14] = '{1, 1, 31'h0000_0001, 31'h0000_0001, 5'd1,  0, 1};

    @(negedge clk);
    do_reset();
    chk_all("reset", '0, '0, 1'b0, 1'b0);

    for (int i = 0; i < 15; i++) begin
      step(tv[i].v, tv[i].en, tv[i].th);
      chk_all($sformatf("vec%0d", i), tv[i].sel, tv[i].p,
              tv[i].err, tv[i].ov);
    end

    // Malformed code straight after reset, then bypass holds the pointer.
    do_reset();
    step(1, 1, 31'h0000_0005);
    chk_all("bad0", 31'h3, 5'd2, 1'b1, 1'b1);
    step(1, 0, 31'h0000_001F);
    chk_all("byp0", 31'h1F, 5'd2, 1'b0, 1'b1);

    // Asynchronous reset between clock edges during a stream.
    step(1, 1, 31'h0000_00FF);
    in_therm = 31'h0000_000F;
    #2 rst = 1'b1;
    #1 chk_all("arst", '0, '0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1, 1, 31'h0000_0007);
    chk_all("post", 31'h7, 5'd3, 1'b0, 1'b1);
    step(0, 1, 31'h0);
    chk("idle.vld", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
